// File: rtl/i2c_sub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : i2c_sub_ctrl                                            |
// | Brief    : I2C subordinate with 8-bit register pointer and strobed |
// |            register read/write port. Define I2C_SUB_GLITCH_FILT_EN |
// |            to add a 3-sample glitch filter on SCL/SDA.             |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module i2c_sub_ctrl #(
   parameter logic [6:0] DEV_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_req,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ADDR      = 4'd1,
      S_ADDR_ACK  = 4'd2,
      S_WR_BYTE   = 4'd3,
      S_WR_ACK    = 4'd4,
      S_RD_LOAD   = 4'd5,
      S_RD_BYTE   = 4'd6,
      S_RD_ACK    = 4'd7,
      S_WAIT_STOP = 4'd8
   } state_t;

   logic [1:0] r_scl_sync, r_sda_sync;
   logic       r_scl_hist, r_sda_hist;
   logic       w_scl_f, w_sda_f;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_i};
         r_sda_sync <= {r_sda_sync[0], sda_i};
      end
   end

`ifdef I2C_SUB_GLITCH_FILT_EN
   logic       r_scl_filt, r_sda_filt;
   logic [1:0] r_scl_run, r_sda_run;

   // A new level is accepted only after three consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
         r_scl_run  <= 2'd0;
         r_sda_run  <= 2'd0;
      end else begin
         if (r_scl_sync[1] == r_scl_filt) begin
            r_scl_run <= 2'd0;
         end else if (r_scl_run == 2'd2) begin
            r_scl_filt <= r_scl_sync[1];
            r_scl_run  <= 2'd0;
         end else begin
            r_scl_run <= r_scl_run + 2'd1;
         end
         if (r_sda_sync[1] == r_sda_filt) begin
            r_sda_run <= 2'd0;
         end else if (r_sda_run == 2'd2) begin
            r_sda_filt <= r_sda_sync[1];
            r_sda_run  <= 2'd0;
         end else begin
            r_sda_run <= r_sda_run + 2'd1;
         end
      end
   end

   assign w_scl_f = r_scl_filt;
   assign w_sda_f = r_sda_filt;
`else
   assign w_scl_f = r_scl_sync[1];
   assign w_sda_f = r_sda_sync[1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_hist <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_hist <= w_scl_f;
         r_sda_hist <= w_sda_f;
      end
   end

   logic w_start, w_stop, w_scl_rise, w_scl_fall;
   assign w_start    = w_scl_f & r_scl_hist & ~w_sda_f &  r_sda_hist;
   assign w_stop     = w_scl_f & r_scl_hist &  w_sda_f & ~r_sda_hist;
   assign w_scl_rise =  w_scl_f & ~r_scl_hist & ~w_start & ~w_stop;
   assign w_scl_fall = ~w_scl_f &  r_scl_hist & ~w_start & ~w_stop;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_shreg, w_shreg_nxt;
   logic [7:0] r_ptr, w_ptr_nxt;
   logic       r_have_ptr, w_have_ptr_nxt;
   logic       r_rw, w_rw_nxt;
   logic [1:0] r_ld_phase, w_ld_phase_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic       r_wr_valid, w_wr_valid_nxt;
   logic [7:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0] r_wr_data, w_wr_data_nxt;
   logic       r_rd_req, w_rd_req_nxt;
   logic [7:0] r_rd_addr, w_rd_addr_nxt;
   logic [7:0] w_byte_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 4'd0;
         r_shreg    <= 8'd0;
         r_ptr      <= 8'd0;
         r_have_ptr <= 1'b0;
         r_rw       <= 1'b0;
         r_ld_phase <= 2'd0;
         r_sda_oe   <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= 8'd0;
         r_wr_data  <= 8'd0;
         r_rd_req   <= 1'b0;
         r_rd_addr  <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shreg    <= w_shreg_nxt;
         r_ptr      <= w_ptr_nxt;
         r_have_ptr <= w_have_ptr_nxt;
         r_rw       <= w_rw_nxt;
         r_ld_phase <= w_ld_phase_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_wr_valid <= w_wr_valid_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_rd_req   <= w_rd_req_nxt;
         r_rd_addr  <= w_rd_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shreg_nxt    = r_shreg;
      w_ptr_nxt      = r_ptr;
      w_have_ptr_nxt = r_have_ptr;
      w_rw_nxt       = r_rw;
      w_ld_phase_nxt = r_ld_phase;
      w_sda_oe_nxt   = r_sda_oe;
      w_wr_valid_nxt = 1'b0;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;
      w_rd_req_nxt   = 1'b0;
      w_rd_addr_nxt  = r_rd_addr;
      w_byte_in      = {r_shreg[6:0], w_sda_f};

      if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_sda_oe_nxt = 1'b0;
      end else if (w_start) begin
         w_state_nxt   = S_ADDR;
         w_bit_cnt_nxt = 4'd0;
         w_sda_oe_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shreg_nxt   = w_byte_in;
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     w_have_ptr_nxt = 1'b0;
                     w_rw_nxt       = w_byte_in[0];
                     w_state_nxt    = (w_byte_in[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                  end
               end
            end
            // Count 8 means "ACK not yet driven", 9 means "ACK on the bus".
            S_ADDR_ACK, S_WR_ACK: begin
               if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     w_sda_oe_nxt  = 1'b1;
                     w_bit_cnt_nxt = 4'd9;
                  end else begin
                     w_sda_oe_nxt  = 1'b0;
                     w_bit_cnt_nxt = 4'd0;
                     w_state_nxt   = S_WR_BYTE;
                  end
               end else if (w_scl_rise && (r_state == S_ADDR_ACK) && r_rw) begin
                  w_state_nxt    = S_RD_LOAD;
                  w_ld_phase_nxt = 2'd0;
               end
            end
            S_WR_BYTE: begin
               if (w_scl_rise) begin
                  w_shreg_nxt   = w_byte_in;
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     w_state_nxt = S_WR_ACK;
                     if (r_have_ptr) begin
                        w_wr_valid_nxt = 1'b1;
                        w_wr_addr_nxt  = r_ptr;
                        w_wr_data_nxt  = w_byte_in;
                        w_ptr_nxt      = r_ptr + 8'd1;
                     end else begin
                        w_ptr_nxt      = w_byte_in;
                        w_have_ptr_nxt = 1'b1;
                     end
                  end
               end
            end
            // Request, wait one cycle for the register file, then capture.
            S_RD_LOAD: begin
               case (r_ld_phase)
                  2'd0: begin
                     w_rd_req_nxt   = 1'b1;
                     w_rd_addr_nxt  = r_ptr;
                     w_ld_phase_nxt = 2'd1;
                  end
                  2'd1: w_ld_phase_nxt = 2'd2;
                  default: begin
                     w_shreg_nxt   = rd_data;
                     w_ptr_nxt     = r_ptr + 8'd1;
                     w_bit_cnt_nxt = 4'd0;
                     w_state_nxt   = S_RD_BYTE;
                  end
               endcase
            end
            S_RD_BYTE: begin
               if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = S_RD_ACK;
                  end else begin
                     w_sda_oe_nxt  = ~r_shreg[7];
                     w_shreg_nxt   = {r_shreg[6:0], 1'b0};
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (w_scl_rise) begin
                  w_ld_phase_nxt = 2'd0;
                  w_state_nxt    = w_sda_f ? S_WAIT_STOP : S_RD_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe   = r_sda_oe;
   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign rd_req   = r_rd_req;
   assign rd_addr  = r_rd_addr;
   assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_sub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_i2c_sub_ctrl                                         |
// | Brief    : Bit-banged I2C controller driving i2c_sub_ctrl against  |
// |            a register-file model; vectors plus random traffic.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_i2c_sub_ctrl;
   localparam logic [6:0] c_dev = 7'h42;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_scl = 1'b1;
   logic        m_sda = 1'b1;
   logic        sda_line, sda_oe, wr_valid, rd_req, busy;
   logic [7:0]  wr_addr, wr_data, rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];
   logic [7:0]  ref_ptr;
   logic [15:0] wr_q[$];
   logic [7:0]  rd_q[$];
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   int          oe_cnt = 0, busy_cnt = 0, pulse_err = 0;
   logic        wr_valid_d = 1'b0;
   int          total = 0, bad = 0;

   assign sda_line = m_sda & ~sda_oe;
   always #5 clk = ~clk;

   i2c_sub_ctrl #(.DEV_ADDR(c_dev)) dut (
      .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
   );

   // Register file attached to the subordinate; contents follow reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      end else begin
         if (wr_valid) mem[wr_addr] <= wr_data;
         if (rd_req) rd_data <= mem[rd_addr];
      end
   end

   always @(negedge clk) begin
      if (wr_valid) wr_q.push_back({wr_addr, wr_data});
      if (rd_req) rd_q.push_back(rd_addr);
      if (wr_valid && wr_valid_d) pulse_err++;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      wr_valid_d = wr_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic ref_reset();
      ref_ptr = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(5); m_scl = 1'b1; tick(5); m_sda = 1'b0; tick(5); m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(5); m_scl = 1'b1; tick(5); m_sda = 1'b1; tick(5);
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         tick(5); m_sda = b[i]; tick(5); m_scl = 1'b1; tick(10); m_scl = 1'b0;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b);
      tick(5); m_sda = 1'b1; tick(5); m_scl = 1'b1; tick(5);
      ack = ~sda_line;
      tick(5); m_scl = 1'b0;
   endtask

   task automatic read_byte(input logic give_ack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         tick(1); m_sda = 1'b1; tick(9); m_scl = 1'b1; tick(5);
         b[i] = sda_line;
         tick(5); m_scl = 1'b0;
      end
      tick(5); m_sda = ~give_ack; tick(5); m_scl = 1'b1; tick(10); m_scl = 1'b0;
   endtask

   task automatic compare_queues(input string tag, input int wbase, input int rbase);
      check({tag, "_wr_cnt"}, 32'(wr_q.size() - wbase), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size(); i++)
         if (wbase + i < wr_q.size()) check({tag, "_wr_evt"}, 32'(wr_q[wbase + i]), 32'(exp_wr[i]));
      check({tag, "_rd_cnt"}, 32'(rd_q.size() - rbase), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size(); i++)
         if (rbase + i < rd_q.size()) check({tag, "_rd_evt"}, 32'(rd_q[rbase + i]), 32'(exp_rd[i]));
      exp_wr.delete();
      exp_rd.delete();
   endtask

   typedef struct {
      logic [7:0] addr_b;
      logic [7:0] ptr;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       exp_ack;
      logic [7:0] exp_a0;
      logic [7:0] exp_a1;
   } vec_t;

   vec_t       vt [4];
   logic       ack, match, is_rd, set_ptr, glitch_exp;
   logic [7:0] b, p, d;
   logic [6:0] a7;
   int         n, wbase, rbase, obase, bbase, k;

   initial begin
      vt[0] = '{8'h84, 8'h10, 8'hA5, 8'h5A, 1'b1, 8'h10, 8'h11};
      vt[1] = '{8'h90, 8'h33, 8'h44, 8'h55, 1'b0, 8'h00, 8'h00};
      vt[2] = '{8'h84, 8'hFF, 8'h01, 8'h02, 1'b1, 8'hFF, 8'h00};
      vt[3] = '{8'h84, 8'h20, 8'h3C, 8'hC3, 1'b1, 8'h20, 8'h21};
      ref_reset();

      tick(3);
      check("reset_outputs", 32'({sda_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy}), 32'h0);
      rst_n = 1'b1;
      tick(5);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_sda_oe", 32'(sda_oe), 32'h0);

      // Write vectors: pointer byte, two data bytes, each ACK checked.
      for (int v = 0; v < 4; v++) begin
         wbase = wr_q.size(); rbase = rd_q.size(); obase = oe_cnt;
         i2c_start();
         check("vec_busy_after_start", 32'(busy), 32'h1);
         write_byte(vt[v].addr_b, ack); check("vec_addr_ack", 32'(ack), 32'(vt[v].exp_ack));
         write_byte(vt[v].ptr, ack);    check("vec_ptr_ack", 32'(ack), 32'(vt[v].exp_ack));
         write_byte(vt[v].d0, ack);     check("vec_d0_ack", 32'(ack), 32'(vt[v].exp_ack));
         write_byte(vt[v].d1, ack);     check("vec_d1_ack", 32'(ack), 32'(vt[v].exp_ack));
         i2c_stop();
         check("vec_busy_after_stop", 32'(busy), 32'h0);
         if (vt[v].exp_ack) begin
            exp_wr.push_back({vt[v].exp_a0, vt[v].d0});
            exp_wr.push_back({vt[v].exp_a1, vt[v].d1});
            ref_mem[vt[v].exp_a0] = vt[v].d0;
            ref_mem[vt[v].exp_a1] = vt[v].d1;
            ref_ptr = vt[v].exp_a1 + 8'd1;
         end else begin
            check("vec_sda_never_driven", 32'(oe_cnt - obase), 32'h0);
         end
         compare_queues("vec", wbase, rbase);
      end

      // Pointer set, repeated START, two-byte read, then NACK leaves bus idle.
      wbase = wr_q.size(); rbase = rd_q.size();
      i2c_start();
      write_byte(8'h84, ack); check("rd_waddr_ack", 32'(ack), 32'h1);
      write_byte(8'h20, ack); check("rd_ptr_ack", 32'(ack), 32'h1);
      i2c_start();
      write_byte(8'h85, ack); check("rd_raddr_ack", 32'(ack), 32'h1);
      read_byte(1'b1, b);     check("rd_byte0", 32'(b), 32'h3C);
      read_byte(1'b0, b);     check("rd_byte1", 32'(b), 32'hC3);
      obase = oe_cnt;
      read_byte(1'b0, b);
      check("rd_after_nack_sda", 32'(oe_cnt - obase), 32'h0);
      i2c_stop();
      exp_rd.push_back(8'h20);
      exp_rd.push_back(8'h21);
      ref_ptr = 8'h22;
      compare_queues("rd", wbase, rbase);

      // Random traffic against the register-file model.
      for (int t = 0; t < 16; t++) begin
         a7 = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : c_dev;
         match = (a7 == c_dev);
         is_rd = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 3);
         p = 8'($urandom);
         wbase = wr_q.size(); rbase = rd_q.size(); obase = oe_cnt;
         i2c_start();
         if (!is_rd) begin
            write_byte({a7, 1'b0}, ack); check("rnd_waddr_ack", 32'(ack), 32'(match));
            if (match) begin
               write_byte(p, ack); check("rnd_ptr_ack", 32'(ack), 32'h1);
               for (int i = 0; i < n; i++) begin
                  d = 8'($urandom);
                  write_byte(d, ack); check("rnd_data_ack", 32'(ack), 32'h1);
                  exp_wr.push_back({p + 8'(i), d});
                  ref_mem[p + 8'(i)] = d;
               end
               ref_ptr = p + 8'(n);
            end else begin
               check("rnd_w_no_drive", 32'(oe_cnt - obase), 32'h0);
            end
         end else begin
            set_ptr = 1'($urandom_range(0, 1));
            if (set_ptr) begin
               write_byte({c_dev, 1'b0}, ack); check("rnd_setp_ack", 32'(ack), 32'h1);
               write_byte(p, ack);             check("rnd_setp_ptr_ack", 32'(ack), 32'h1);
               ref_ptr = p;
               i2c_start();
               obase = oe_cnt;
            end
            write_byte({a7, 1'b1}, ack); check("rnd_raddr_ack", 32'(ack), 32'(match));
            if (match) begin
               for (int i = 0; i < n; i++) begin
                  read_byte(i != n - 1, b);
                  check("rnd_read_data", 32'(b), 32'(ref_mem[ref_ptr + 8'(i)]));
                  exp_rd.push_back(ref_ptr + 8'(i));
               end
               ref_ptr = ref_ptr + 8'(n);
            end else begin
               check("rnd_r_no_drive", 32'(oe_cnt - obase), 32'h0);
            end
         end
         i2c_stop();
         check("rnd_busy_after_stop", 32'(busy), 32'h0);
         compare_queues("rnd", wbase, rbase);
      end

      // Reset while the address ACK is on the bus.
      i2c_start();
      send_bits(8'h84);
      k = 0;
      while (!sda_oe && k < 30) begin tick(1); k++; end
      check("mid_ack_driving", 32'(sda_oe), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_ack_async_release", 32'(sda_oe), 32'h0);
      check("mid_ack_outputs", 32'({sda_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy}), 32'h0);
      tick(2); m_scl = 1'b1; tick(2); m_sda = 1'b1; tick(2);
      rst_n = 1'b1;
      ref_reset();
      tick(5);
      bbase = busy_cnt;
      m_scl = 1'b0; tick(5);
      write_byte(8'h84, ack); check("post_reset_no_ack", 32'(ack), 32'h0);
      check("post_reset_no_busy", 32'(busy_cnt - bbase), 32'h0);
      i2c_stop();
      i2c_start();
      write_byte(8'h84, ack); check("post_reset_ack", 32'(ack), 32'h1);
      i2c_stop();

      // Two-clock SDA dip while SCL is high.
`ifdef I2C_SUB_GLITCH_FILT_EN
      glitch_exp = 1'b0;
`else
      glitch_exp = 1'b1;
`endif
      tick(5);
      bbase = busy_cnt;
      m_sda = 1'b0; tick(2); m_sda = 1'b1; tick(20);
      check("glitch_start_seen", 32'(busy_cnt != bbase), 32'(glitch_exp));
      check("glitch_busy_end", 32'(busy), 32'h0);

      check("wr_valid_single_clk", 32'(pulse_err), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/i2c_sub_ctrl.md
I2C_SUB_CTRL -- requirements
Module: i2c_sub_ctrl

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, 7-bit subordinate address matched after START.
REQ-002 SHALL have port clk  in  1  system clock; the only clock, with clk at least 16x the SCL frequency.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port scl_i  in  1  raw SCL, asynchronous to clk.
REQ-005 SHALL have port sda_i  in  1  raw SDA, asynchronous to clk.
REQ-006 SHALL have port sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 SHALL have ports wr_valid / wr_addr / wr_data  out  1/8/8  register-write strobe, pointer and data byte.
REQ-008 SHALL have ports rd_req / rd_addr  out  1/8  register-read strobe and pointer.
REQ-009 SHALL have port rd_data  in  8  read data, valid the clk cycle after rd_req.
REQ-010 SHALL have port busy  out  1  high from a START until STOP or IDLE is reached.

Function
REQ-011 SHALL pass scl_i and sda_i through 2-flop synchronizers plus one history flop; edges are derived from the last two stages.
REQ-012 SHALL flag START when SDA falls with SCL high, and STOP when SDA rises with SCL high, each 3 clk after the raw edge.
REQ-013 SHALL sample SDA on each detected SCL rising edge, and SHALL change sda_oe only on the clk after a detected SCL falling edge.
REQ-014 SHALL implement the following states:
- IDLE
- ADDR: 8 bits, MSB first
- ADDR_ACK
- WR_BYTE
- WR_ACK
- RD_LOAD
- RD_BYTE
- RD_ACK
- WAIT_STOP
REQ-015 SHALL move to ADDR from any state on START (repeated START included), clear the bit counter and release sda_oe that cycle.
REQ-016 SHALL move to IDLE from any state on STOP, release sda_oe and drop busy on the next clk.
REQ-017 SHALL handle address match as follows:
- match: drive ACK (sda_oe=1) for the 9th SCL period.
- R/W=0: go to WR_BYTE.
- R/W=1: go to RD_LOAD.
- mismatch: no ACK; go to WAIT_STOP.
REQ-018 SHALL treat the first byte after a write address as the 8-bit pointer (no wr_valid), and each following byte as data.
REQ-019 SHALL, for each write data byte, pulse wr_valid for exactly 1 clk after the 8th SCL rise, with wr_addr=pointer; the pointer then increments.
REQ-020 SHALL ACK every write byte, including the pointer byte.
REQ-021 SHALL in RD_LOAD pulse rd_req for 1 clk with rd_addr=pointer, load rd_data on the next clk, then increment the pointer.
REQ-022 SHALL in RD_BYTE drive sda_oe=~bit, MSB first, changing after SCL falls, and release SDA during RD_ACK.
REQ-023 SHALL in RD_ACK go to RD_LOAD if the controller sampled ACK (SDA=0), or to WAIT_STOP if it sampled NACK.
REQ-024 SHALL wrap the pointer from 8'hFF to 8'h00.
REQ-025 SHALL, when START/STOP and an SCL edge are detected in the same clk, let START/STOP win and ignore the SCL edge.

Reset
REQ-026 SHALL on rst_n low immediately set state=IDLE, with all of the following zero: sda_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, pointer, shift register, bit counter.
REQ-027 SHALL release SDA asynchronously on reset mid-transfer, and SHALL not react to the bus until a new START.

Configuration
REQ-028 SHALL, with I2C_SUB_GLITCH_FILT_EN defined, update filtered SCL/SDA only after 3 consecutive equal synchronized samples; edge latency becomes 6 clk and pulses of 2 clk or fewer are ignored.
REQ-029 SHALL, without I2C_SUB_GLITCH_FILT_EN, use synchronized samples directly, per REQ-011 and REQ-012.

Verification
REQ-030 SHALL cover write: START, 0x84, 0x10, 0xA5, 0x5A, STOP -> ACKs on all 4 bytes; wr_valid with (0x10,0xA5) then (0x11,0x5A); busy low after STOP.
REQ-031 SHALL cover read: START, 0x84, 0x20, rSTART, 0x85, master ACK then NACK, rd_data=0x3C,0xC3 -> rd_addr 0x20,0x21; SDA bytes 0x3C,0xC3; WAIT_STOP after NACK.
REQ-032 SHALL cover wrong address: START, 0x90 -> SDA never driven; no strobes; next START, 0x84 -> ACK.
REQ-033 SHALL cover pointer wrap: write pointer 0xFF, data 0x01, 0x02 -> wr_addr 0xFF then 0x00.
REQ-034 SHALL cover reset mid-ACK: assert rst_n=0 while sda_oe=1 -> sda_oe=0 in same cycle, all outputs zero, state IDLE.
REQ-035 SHALL cover the filter: with I2C_SUB_GLITCH_FILT_EN, a 2-clk SDA low pulse while SCL high -> no START; without the macro -> START detected.
